response_uart_tx: RTL and testbench

- Downstream consumer of the PUF response buffer.
- Detects each rising edge of ready_to_read and captures the 8-bit response on that edge.
- Transmits the response over a UART 8N1 line as two uppercase ASCII hex characters followed by CR LF.
- Sits between the response buffer and the board's USB-UART bridge pin, so the host can collect challenge responses.

---
 rtl/response_uart_tx_if.sv | 28 ++
 rtl/response_uart_tx.sv | 153 +++++++++++++++
 tb/tb_response_uart_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/response_uart_tx_if.sv
// Handshake bundle between the PUF response buffer and the UART sender.
// The buffer side is the master, the UART sender is the slave.
interface response_uart_tx_if;
    logic [7:0] response;
    logic       ready_to_read;
    logic       tx;
    logic       busy;
    logic       sent;
    logic       overrun;

    modport master (
        output response,
        output ready_to_read,
        input  tx,
        input  busy,
        input  sent,
        input  overrun
    );

    modport slave (
        input  response,
        input  ready_to_read,
        output tx,
        output busy,
        output sent,
        output overrun
    );
endinterface

// File: rtl/response_uart_tx.sv
// Sends each captured PUF response as two hex chars plus CR LF
// over a UART 8N1 line.
module response_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input logic              clk,
    input logic              rst_n,
    response_uart_tx_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             ready_d_q;
    logic [1:0]       state_q,    state_d;
    logic [1:0]       char_idx_q, char_idx_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       resp_q,     resp_d;
    logic             busy_q,     busy_d;
    logic             sent_q,     sent_d;
    logic             overrun_q,  overrun_d;
    logic             tx_q,       tx_d;

    logic             trig;
    logic             bit_done;
    logic [7:0]       char_d;

    function automatic logic [7:0] hex(input logic [3:0] n);
        if (n <= 4'd9) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] enc(
        input logic [7:0] r,
        input logic [1:0] idx
    );
        logic [7:0] c;
        unique case (idx)
            2'd0:    c = hex(r[7:4]);
            2'd1:    c = hex(r[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    assign trig     = bus.ready_to_read & ~ready_d_q;
    assign bit_done = (cnt_q == CNT_MAX);

    // Next-state logic: bit timing, character sequencing, flags.
    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        bit_cnt_d  = bit_cnt_q;
        resp_d     = resp_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;
        overrun_d  = overrun_q;
        cnt_d      = (state_q == S_IDLE || bit_done) ? '0
                                                     : cnt_q + CNT_ONE;

        if (trig && state_q != S_IDLE) overrun_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    resp_d     = bus.response;
                    char_idx_d = 2'd0;
                    bit_cnt_d  = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (char_idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        sent_d  = 1'b1;
                    end else begin
                        char_idx_d = char_idx_q + 2'd1;
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign char_d = enc(resp_d, char_idx_d);

    // Line level for the upcoming cycle, registered to keep tx glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = char_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_d_q  <= 1'b0;
            state_q    <= S_IDLE;
            char_idx_q <= 2'd0;
            bit_cnt_q  <= 3'd0;
            cnt_q      <= '0;
            resp_q     <= 8'h00;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            overrun_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            ready_d_q  <= bus.ready_to_read;
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            overrun_q  <= overrun_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.sent    = sent_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_response_uart_tx.sv
// Bench for response_uart_tx: table of responses plus corner sequences,
// with a UART line decoder checking bytes against an expected queue.
module tb_response_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;

    response_uart_tx_if bus();

    response_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0] exp_q[$];

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Line decoder: samples every bit at its middle.
    bit         mon_act = 1'b0;
    int         mon_cyc = 0;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (bus.tx == 1'b0) begin
                mon_act = 1'b1;
                mon_cyc = 0;
            end
        end else begin
            mon_cyc++;
            if (mon_cyc % CPB == CPB / 2) begin
                if (mon_cyc / CPB == 0) begin
                    chk("start_bit", {31'd0, bus.tx}, 32'd0);
                end else if (mon_cyc / CPB <= 8) begin
                    mon_byte[mon_cyc / CPB - 1] = bus.tx;
                end else begin
                    chk("stop_bit", {31'd0, bus.tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("rx_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    // One message: rise, optional retrigger at cycle rt_cyc, measure busy.
    task automatic run_msg(
        input logic [7:0]  r,
        input logic [31:0] ch,
        input int          rt_cyc,
        input logic [7:0]  rt_resp,
        input logic        exp_ovr,
        input logic        drop
    );
        int n;
        int sc;
        @(negedge clk);
        bus.response      = r;
        bus.ready_to_read = 1'b1;
        exp_q.push_back(ch[31:24]);
        exp_q.push_back(ch[23:16]);
        exp_q.push_back(ch[15:8]);
        exp_q.push_back(ch[7:0]);
        @(negedge clk);
        chk("start_lat_tx", {31'd0, bus.tx}, 32'd0);
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        n  = 1;
        sc = 0;
        while (1) begin
            if (n == rt_cyc - 5) bus.ready_to_read = 1'b0;
            if (n == rt_cyc) begin
                bus.ready_to_read = 1'b1;
                bus.response      = rt_resp;
            end
            @(negedge clk);
            sc += int'(bus.sent);
            if (!bus.busy || n >= 400) break;
            n++;
        end
        repeat (3) begin
            @(negedge clk);
            sc += int'(bus.sent);
        end
        chk("busy_len", n, 160);
        chk("sent_pulses", sc, 1);
        chk("overrun", {31'd0, bus.overrun}, {31'd0, exp_ovr});
        chk("bytes_drained", exp_q.size(), 0);
        if (drop) bus.ready_to_read = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  resp;
        logic [31:0] chars;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int busy_n;
        int tx_low;
        int sent_n;

        vecs[0] = '{8'hA5, 32'h4135_0D0A};
        vecs[1] = '{8'h00, 32'h3030_0D0A};
        vecs[2] = '{8'hFF, 32'h4646_0D0A};
        vecs[3] = '{8'h9A, 32'h3941_0D0A};
        vecs[4] = '{8'h0F, 32'h3046_0D0A};

        rst_n             = 1'b0;
        bus.response      = 8'h00;
        bus.ready_to_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, bus.tx}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_sent", {31'd0, bus.sent}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_msg(vecs[i].resp, vecs[i].chars, -1, 8'h00, 1'b0, 1'b1);
        end

        // Level held high: one message only.
        run_msg(8'hC3, 32'h4333_0D0A, -1, 8'h00, 1'b0, 1'b0);
        tx_low = 0;
        sent_n = 0;
        busy_n = 0;
        repeat (1000) begin
            @(negedge clk);
            tx_low += int'(!bus.tx);
            sent_n += int'(bus.sent);
            busy_n += int'(bus.busy);
        end
        chk("hold_tx_low", tx_low, 0);
        chk("hold_sent", sent_n, 0);
        chk("hold_busy", busy_n, 0);
        bus.ready_to_read = 1'b0;
        repeat (2) @(negedge clk);

        // Retrigger mid-message with a new response.
        run_msg(8'h5A, 32'h3541_0D0A, 50, 8'h3C, 1'b1, 1'b1);
        busy_n = 0;
        repeat (200) begin
            @(negedge clk);
            busy_n += int'(bus.busy);
        end
        chk("ovr_no_second", busy_n, 0);
        chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);

        // Reset in the middle of character 1.
        @(negedge clk);
        bus.response      = 8'h10;
        bus.ready_to_read = 1'b1;
        exp_q.push_back(8'h31);
        repeat (50) @(negedge clk);
        chk("pre_rst_tx", {31'd0, bus.tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, bus.tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_overrun", {31'd0, bus.overrun}, 32'd0);
        chk("mid_rst_sent", {31'd0, bus.sent}, 32'd0);
        bus.ready_to_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_char0_seen", exp_q.size(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_msg(8'h7E, 32'h3745_0D0A, -1, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Retrigger on the cycle busy falls, then again 5 cycles later.
        run_msg(8'h2B, 32'h3242_0D0A, 160, 8'h99, 1'b1, 1'b0);
        @(negedge clk);
        bus.ready_to_read = 1'b0;
        repeat (4) @(negedge clk);
        run_msg(8'hD4, 32'h4434_0D0A, -1, 8'h00, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
